// File: rtl/operand_fetch_pkg.sv
// ============================================================================
// Module : operand_fetch_pkg
// Brief  : Shared rv32i field positions and width defaults for operand fetch.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package operand_fetch_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_PC_WIDTH   = 32;
  localparam int INSTR_WIDTH    = 32;

  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

`default_nettype wire

// File: rtl/operand_bypass.sv
// ============================================================================
// Module : operand_bypass
// Brief  : Resolves one source operand from rf data and the two writeback views.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module operand_bypass
  import operand_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] idx_i,
  input  logic [DATA_WIDTH-1:0] rf_data_i,
  input  logic                  wb_we_i,
  input  logic [ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  input  logic                  last_wb_we_i,
  input  logic [ADDR_WIDTH-1:0] last_wb_addr_i,
  input  logic [DATA_WIDTH-1:0] last_wb_data_i,
  output logic [DATA_WIDTH-1:0] operand_o
);

  // The rf returns the pre-write value when a write lands on its sample edge,
  // so the previous-edge write must override the rf data.
  always_comb begin
    operand_o = rf_data_i;
    if (idx_i == ADDR_WIDTH'(REG_ZERO)) begin
      operand_o = '0;
    end else if (wb_we_i && (wb_addr_i == idx_i)) begin
      operand_o = wb_data_i;
    end else if (last_wb_we_i && (last_wb_addr_i == idx_i)) begin
      operand_o = last_wb_data_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/operand_fetch.sv
// ============================================================================
// Module : operand_fetch
// Brief  : Two-slot operand fetch stage with writeback bypass and output snoop.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int PC_WIDTH   = DEF_PC_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_WIDTH-1:0] in_instr,
  input  logic [PC_WIDTH-1:0]    in_pc,
  output logic [ADDR_WIDTH-1:0]  rf_rs1_addr,
  output logic [ADDR_WIDTH-1:0]  rf_rs2_addr,
  input  logic [DATA_WIDTH-1:0]  rf_rs1_data,
  input  logic [DATA_WIDTH-1:0]  rf_rs2_data,
  input  logic                   wb_we,
  input  logic [ADDR_WIDTH-1:0]  wb_addr,
  input  logic [DATA_WIDTH-1:0]  wb_data,
  output logic                   ex_valid,
  input  logic                   ex_ready,
  output logic [INSTR_WIDTH-1:0] ex_instr,
  output logic [PC_WIDTH-1:0]    ex_pc,
  output logic [DATA_WIDTH-1:0]  ex_rs1,
  output logic [DATA_WIDTH-1:0]  ex_rs2
);

  logic                   a_valid_q, a_valid_d;
  logic [INSTR_WIDTH-1:0] a_instr_q, a_instr_d;
  logic [PC_WIDTH-1:0]    a_pc_q, a_pc_d;
  logic                   ex_valid_q, ex_valid_d;
  logic [INSTR_WIDTH-1:0] ex_instr_q, ex_instr_d;
  logic [PC_WIDTH-1:0]    ex_pc_q, ex_pc_d;
  logic [DATA_WIDTH-1:0]  ex_rs1_q, ex_rs1_d;
  logic [DATA_WIDTH-1:0]  ex_rs2_q, ex_rs2_d;
  logic                   last_wb_we_q;
  logic [ADDR_WIDTH-1:0]  last_wb_addr_q;
  logic [DATA_WIDTH-1:0]  last_wb_data_q;

  logic                   x_free;
  logic                   a_move;
  logic                   accept;
  logic                   snoop;
  logic [INSTR_WIDTH-1:0] addr_instr;
  logic [DATA_WIDTH-1:0]  rs1_res;
  logic [DATA_WIDTH-1:0]  rs2_res;

  assign x_free   = !ex_valid_q || ex_ready;
  assign a_move   = a_valid_q && x_free;
  assign in_ready = !flush && (!a_valid_q || a_move);
  assign accept   = in_valid && in_ready;
  assign snoop    = ex_valid_q && !ex_ready && wb_we && (wb_addr != ADDR_WIDTH'(REG_ZERO));

  // A stalled slot A re-reads its own registers every cycle so its data stays fresh.
  assign addr_instr  = (a_valid_q && !a_move) ? a_instr_q : in_instr;
  assign rf_rs1_addr = addr_instr[RS1_LSB +: ADDR_WIDTH];
  assign rf_rs2_addr = addr_instr[RS2_LSB +: ADDR_WIDTH];

  operand_bypass #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bypass_rs1 (
    .idx_i          (a_instr_q[RS1_LSB +: ADDR_WIDTH]),
    .rf_data_i      (rf_rs1_data),
    .wb_we_i        (wb_we),
    .wb_addr_i      (wb_addr),
    .wb_data_i      (wb_data),
    .last_wb_we_i   (last_wb_we_q),
    .last_wb_addr_i (last_wb_addr_q),
    .last_wb_data_i (last_wb_data_q),
    .operand_o      (rs1_res)
  );

  operand_bypass #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bypass_rs2 (
    .idx_i          (a_instr_q[RS2_LSB +: ADDR_WIDTH]),
    .rf_data_i      (rf_rs2_data),
    .wb_we_i        (wb_we),
    .wb_addr_i      (wb_addr),
    .wb_data_i      (wb_data),
    .last_wb_we_i   (last_wb_we_q),
    .last_wb_addr_i (last_wb_addr_q),
    .last_wb_data_i (last_wb_data_q),
    .operand_o      (rs2_res)
  );

  always_comb begin
    a_valid_d  = a_valid_q;
    a_instr_d  = a_instr_q;
    a_pc_d     = a_pc_q;
    ex_valid_d = ex_valid_q;
    ex_instr_d = ex_instr_q;
    ex_pc_d    = ex_pc_q;
    ex_rs1_d   = ex_rs1_q;
    ex_rs2_d   = ex_rs2_q;

    if (flush) begin
      a_valid_d  = 1'b0;
      ex_valid_d = 1'b0;
    end else begin
      if (accept) begin
        a_valid_d = 1'b1;
        a_instr_d = in_instr;
        a_pc_d    = in_pc;
      end else if (a_move) begin
        a_valid_d = 1'b0;
      end

      if (a_move) begin
        ex_valid_d = 1'b1;
        ex_instr_d = a_instr_q;
        ex_pc_d    = a_pc_q;
        ex_rs1_d   = rs1_res;
        ex_rs2_d   = rs2_res;
      end else begin
        if (ex_ready) begin
          ex_valid_d = 1'b0;
        end
        // A held output entry tracks writebacks to its source registers.
        if (snoop) begin
          if (ex_instr_q[RS1_LSB +: ADDR_WIDTH] == wb_addr) ex_rs1_d = wb_data;
          if (ex_instr_q[RS2_LSB +: ADDR_WIDTH] == wb_addr) ex_rs2_d = wb_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_q      <= 1'b0;
      a_instr_q      <= '0;
      a_pc_q         <= '0;
      ex_valid_q     <= 1'b0;
      ex_instr_q     <= '0;
      ex_pc_q        <= '0;
      ex_rs1_q       <= '0;
      ex_rs2_q       <= '0;
      last_wb_we_q   <= 1'b0;
      last_wb_addr_q <= '0;
      last_wb_data_q <= '0;
    end else begin
      a_valid_q      <= a_valid_d;
      a_instr_q      <= a_instr_d;
      a_pc_q         <= a_pc_d;
      ex_valid_q     <= ex_valid_d;
      ex_instr_q     <= ex_instr_d;
      ex_pc_q        <= ex_pc_d;
      ex_rs1_q       <= ex_rs1_d;
      ex_rs2_q       <= ex_rs2_d;
      last_wb_we_q   <= wb_we;
      last_wb_addr_q <= wb_addr;
      last_wb_data_q <= wb_data;
    end
  end

  assign ex_valid = ex_valid_q;
  assign ex_instr = ex_instr_q;
  assign ex_pc    = ex_pc_q;
  assign ex_rs1   = ex_rs1_q;
  assign ex_rs2   = ex_rs2_q;

endmodule

`default_nettype wire

// File: tb/tb_operand_fetch.sv
// ============================================================================
// Module : tb_operand_fetch
// Brief  : Scoreboard bench for operand_fetch with a behavioural register file.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_operand_fetch;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [4:0]  rf_rs1_addr;
  logic [4:0]  rf_rs2_addr;
  logic [31:0] rf_rs1_data;
  logic [31:0] rf_rs2_data;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_instr;
  logic [31:0] ex_pc;
  logic [31:0] ex_rs1;
  logic [31:0] ex_rs2;

  int checks = 0;
  int errors = 0;

  logic [31:0] regs [32];
  logic [31:0] q_instr [$];
  logic [31:0] q_pc [$];

  operand_fetch u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .rf_rs1_addr (rf_rs1_addr),
    .rf_rs2_addr (rf_rs2_addr),
    .rf_rs1_data (rf_rs1_data),
    .rf_rs2_data (rf_rs2_data),
    .wb_we       (wb_we),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_instr    (ex_instr),
    .ex_pc       (ex_pc),
    .ex_rs1      (ex_rs1),
    .ex_rs2      (ex_rs2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read register file that returns the old value on a same-edge write.
  always @(posedge clk) begin
    rf_rs1_data <= regs[rf_rs1_addr];
    rf_rs2_data <= regs[rf_rs2_addr];
    if (wb_we) regs[wb_addr] <= wb_data;
  end

  function automatic logic [31:0] arch_reg(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'h0 : regs[idx];
  endfunction

  function automatic logic [31:0] mk(input int rs1, input int rs2);
    return {7'h00, 5'(rs2), 5'(rs1), 3'b000, 5'd1, 7'h33};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue side: every accepted instruction is owed one output entry.
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      q_instr.delete();
      q_pc.delete();
    end else if (in_valid && in_ready) begin
      q_instr.push_back(in_instr);
      q_pc.push_back(in_pc);
    end
  end

  // Consumed operands must equal the architectural register value at hand-off.
  always @(negedge clk) begin
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    if (rst_n && !flush && ex_valid && ex_ready) begin
      if (q_instr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got output pc %h expected none pending", ex_pc);
      end else begin
        e_instr = q_instr.pop_front();
        e_pc    = q_pc.pop_front();
        chk("sb_instr", ex_instr, e_instr);
        chk("sb_pc", ex_pc, e_pc);
        chk("sb_rs1", ex_rs1, arch_reg(e_instr[19:15]));
        chk("sb_rs2", ex_rs2, arch_reg(e_instr[24:20]));
      end
    end
  end

  initial begin
    logic [31:0] r;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    ex_ready = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;

    for (int i = 1; i < 32; i++) begin
      wb_we = 1'b1; wb_addr = 5'(i);
      wb_data = (i == 1) ? 32'h11 : 32'h1000_0000 + 32'(i);
      tick();
    end
    wb_we = 1'b0;
    tick();
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    tick();
    chk("rst_ex_instr", ex_instr, 32'h0);
    chk("rst_ex_pc", ex_pc, 32'h0);
    chk("rst_ex_rs1", ex_rs1, 32'h0);
    chk("rst_ex_rs2", ex_rs2, 32'h0);

    // single instruction, x1 preloaded
    ex_ready = 1'b1; in_valid = 1'b1; in_instr = mk(1, 0); in_pc = 32'h100;
    #1;
    chk("single_rf_addr", 32'(rf_rs1_addr), 32'd1);
    chk("single_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("lat_e0_valid", 32'(ex_valid), 32'd0);
    tick();
    chk("lat_e1_valid", 32'(ex_valid), 32'd1);
    chk("single_rs1", ex_rs1, 32'h11);
    chk("single_rs2", ex_rs2, 32'h0);
    tick();
    chk("single_drained", 32'(ex_valid), 32'd0);

    // back-to-back stream
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_instr = mk(i + 2, i + 3); in_pc = 32'(4 * i);
      #1;
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      tick();
      if (i > 0) begin
        chk("stream_valid", 32'(ex_valid), 32'd1);
        chk("stream_pc", ex_pc, 32'(4 * (i - 1)));
      end
    end
    in_valid = 1'b0;
    tick();
    chk("stream_valid", 32'(ex_valid), 32'd1);
    chk("stream_pc", ex_pc, 32'hC);
    tick();

    // write on the rf sample edge
    in_valid = 1'b1; in_instr = mk(5, 0); in_pc = 32'h200;
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD;
    tick();
    in_valid = 1'b0; wb_we = 1'b0;
    tick();
    chk("wb_sample_edge", ex_rs1, 32'hDEAD);

    // write on the capture edge, then a write to x0
    in_valid = 1'b1; in_instr = mk(5, 0); in_pc = 32'h204;
    tick();
    in_valid = 1'b0; wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hBEEF;
    tick();
    wb_we = 1'b0;
    chk("wb_capture_edge", ex_rs1, 32'hBEEF);
    in_valid = 1'b1; in_instr = mk(5, 0); in_pc = 32'h208;
    tick();
    in_valid = 1'b0; wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hFF;
    tick();
    wb_we = 1'b0;
    chk("x0_write_rs2", ex_rs2, 32'h0);
    tick();

    // output stall with A occupied
    ex_ready = 1'b0; in_valid = 1'b1; in_instr = mk(3, 7); in_pc = 32'h300;
    tick();
    in_instr = mk(8, 9); in_pc = 32'h304;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_rs1_addr", 32'(rf_rs1_addr), 32'd8);
      chk("stall_rs2_addr", 32'(rf_rs2_addr), 32'd9);
      wb_we = (k == 1); wb_addr = 5'd7; wb_data = 32'h77;
      tick();
    end
    wb_we = 1'b0;
    chk("snoop_rs2", ex_rs2, 32'h77);
    chk("stall_head_pc", ex_pc, 32'h300);
    ex_ready = 1'b1;
    tick();
    chk("release_valid", 32'(ex_valid), 32'd1);
    chk("release_pc", ex_pc, 32'h304);
    tick();
    chk("release_drained", 32'(ex_valid), 32'd0);

    // flush with both slots full
    ex_ready = 1'b0; in_valid = 1'b1; in_instr = mk(1, 2); in_pc = 32'h400;
    tick();
    in_instr = mk(3, 4); in_pc = 32'h404;
    tick();
    in_instr = mk(5, 6); in_pc = 32'h408; flush = 1'b1; ex_ready = 1'b1;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_ex_valid", 32'(ex_valid), 32'd0);
    tick();
    chk("flush_a_killed", 32'(ex_valid), 32'd0);

    // reset pulse mid-stream
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_instr = mk(i, i + 1); in_pc = 32'h500 + 32'(4 * i);
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk("rstmid_ex_valid", 32'(ex_valid), 32'd0);
    chk("rstmid_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // randomized traffic, registers limited to x0..x7 to provoke bypassing
    for (int c = 0; c < 400; c++) begin
      r = $urandom;
      r[24:23] = 2'b00;
      r[19:18] = 2'b00;
      in_valid = ($urandom_range(3) != 0);
      in_instr = r;
      in_pc    = 32'h1000 + 32'(4 * c);
      ex_ready = ($urandom_range(2) != 0);
      wb_we    = $urandom_range(1) == 1;
      wb_addr  = 5'($urandom_range(7));
      wb_data  = $urandom;
      flush    = ($urandom_range(39) == 0);
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; wb_we = 1'b0; ex_ready = 1'b1;
    repeat (4) tick();
    chk("drain_empty", 32'(q_instr.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
